// File: rtl/tdc_enc_pkg.sv
// Shared constants for the FPMROC TDC encoder chain: delay-line width, fine-code
// width and the bit layout of the packed timestamp {err, coarse, fine}.
package tdc_enc_pkg;
    localparam int TDL_W      = 11;
    localparam int FINE_W     = 4;
    localparam logic [FINE_W-1:0] FINE_NONE = 4'hF;
    localparam int FINE_LSB   = 0;
    localparam int COARSE_LSB = 4;

    function automatic int err_bit(input int coarse_w);
        return COARSE_LSB + coarse_w;
    endfunction
endpackage

// File: rtl/find_one.sv
// Delay-line priority encoder: index of the lowest set bit of the sampled word,
// FINE_NONE when no bit is set.
module find_one
    import tdc_enc_pkg::*;
(
    input  logic [TDL_W-1:0]  din_i,
    output logic [FINE_W-1:0] pos_o
);
    always_comb begin
        pos_o = FINE_NONE;
        for (int i = TDL_W - 1; i >= 0; i--) begin
            if (din_i[i]) pos_o = FINE_W'(i);
        end
    end
endmodule

// File: rtl/tdc_evt_fifo.sv
// Synchronous show-ahead FIFO for packed timestamps. Head entry is presented
// combinationally; when empty the output holds the last word popped.
module tdc_evt_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    output logic         wr_ok_o,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  last_q;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          valid_q, valid_d, full_q, full_d;
    logic          rd_fire, wr_fire;

    // A write into a full FIFO is still taken when the head leaves this cycle.
    assign rd_fire = rd_i & valid_q;
    assign wr_fire = wr_i & (~full_q | rd_fire);

    always_comb begin
        wr_ptr_d = wr_fire ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        valid_d  = (wr_ptr_d != rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            if (rd_fire) last_q <= mem_q[rd_ptr_q[AW-1:0]];
            if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = valid_q ? mem_q[rd_ptr_q[AW-1:0]] : last_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;
    assign wr_ok_o = wr_fire;
endmodule

// File: rtl/tdc_hit_packer.sv
// Captures TDL words on hit strobes, encodes the fine code, pairs it with the
// coarse counter and queues {err, coarse, fine}. Optional TDC_BUBBLE_FILTER_EN.
module tdc_hit_packer
    import tdc_enc_pkg::*;
#(
    parameter int COARSE_W = 10,
    parameter int DEPTH    = 4,
    parameter int OVF_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         hit_i,
    input  logic [TDL_W-1:0]             tdl_i,
    output logic [err_bit(COARSE_W):0]   dout_o,
    output logic                         dout_valid_o,
    input  logic                         dout_ready_i,
    output logic [OVF_W-1:0]             ovf_cnt_o,
    output logic                         full_o
);
    localparam int OUT_W = err_bit(COARSE_W) + 1;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
    endfunction

    logic [COARSE_W-1:0] coarse_q;
    logic [TDL_W-1:0]    tdl_p0_q;
    logic [COARSE_W-1:0] crs_p0_q;
    logic                vld_p0_q;
    logic [TDL_W-1:0]    enc_tdl;
    logic [COARSE_W-1:0] enc_crs;
    logic                enc_vld;
    logic [FINE_W-1:0]   fine_raw;
    logic                err;
    logic [OUT_W-1:0]    word_p1_q, word_p1_d;
    logic                vld_p1_q;
    logic                wr_ok;
    logic [OVF_W-1:0]    ovf_q;

    // S0: capture word and pre-increment coarse value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_q <= '0;
            tdl_p0_q <= '0;
            crs_p0_q <= '0;
            vld_p0_q <= 1'b0;
        end else begin
            if (en_i) coarse_q <= coarse_q + {{(COARSE_W-1){1'b0}}, 1'b1};
            vld_p0_q <= hit_i & en_i;
            if (hit_i & en_i) begin
                tdl_p0_q <= tdl_i;
                crs_p0_q <= coarse_q;
            end
        end
    end

`ifdef TDC_BUBBLE_FILTER_EN
    logic [TDL_W-1:0]    tdl_pf_q;
    logic [COARSE_W-1:0] crs_pf_q;
    logic                vld_pf_q;

    // Filter stage: a bit survives only if the bit above it is also set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdl_pf_q <= '0;
            crs_pf_q <= '0;
            vld_pf_q <= 1'b0;
        end else begin
            tdl_pf_q <= {tdl_p0_q[TDL_W-1], tdl_p0_q[TDL_W-1:1] & tdl_p0_q[TDL_W-2:0]};
            crs_pf_q <= crs_p0_q;
            vld_pf_q <= vld_p0_q;
        end
    end

    assign enc_tdl = tdl_pf_q;
    assign enc_crs = crs_pf_q;
    assign enc_vld = vld_pf_q;
`else
    assign enc_tdl = tdl_p0_q;
    assign enc_crs = crs_p0_q;
    assign enc_vld = vld_p0_q;
`endif

    find_one u_find_one (
        .din_i (enc_tdl),
        .pos_o (fine_raw)
    );

    assign err       = (enc_tdl == '0);
    assign word_p1_d = {err, enc_crs, err ? FINE_NONE : fine_raw};

    // S1: packed word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            word_p1_q <= word_p1_d;
            vld_p1_q  <= enc_vld;
        end
    end

    // S2: FIFO write; refused writes count as dropped hits
    tdc_evt_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (vld_p1_q),
        .wdata_i (word_p1_q),
        .wr_ok_o (wr_ok),
        .rd_i    (dout_ready_i),
        .rdata_o (dout_o),
        .valid_o (dout_valid_o),
        .full_o  (full_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ovf_q <= '0;
        else if (vld_p1_q & ~wr_ok) ovf_q <= sat_inc(ovf_q);
    end

    assign ovf_cnt_o = ovf_q;
endmodule
